// File: rtl/foreign_fetch_linequeue.sv
// Sequential-address line queue feeding the x86 length-decode stage.
// Optional same-cycle empty-queue bypass is enabled by defining FOREIGN_FQ_BYPASS_EN.
module foreign_fetch_linequeue #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 48
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [511:0]               line_in,
   input  logic                       line_in_en,
   input  logic [ADDR_W-1:0]          line_in_addr,
   input  logic                       line_in_fault,
   output logic                       line_in_rdy,
   input  logic                       follow_req,
   input  logic                       flush,
   input  logic [ADDR_W-1:0]          flush_addr,
   output logic [511:0]               data_out,
   output logic                       data_out_en,
   output logic [ADDR_W-1:0]          data_out_addr,
   output logic                       data_out_error,
   output logic                       seq_err,
   output logic                       ovf_err,
   output logic [$clog2(DEPTH+1)-1:0] fq_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned LA_W  = ADDR_W - 6;

   typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

   state_e            state;
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [CNT_W-1:0]  count;
   logic [LA_W-1:0]   expected_line;

   logic [511:0]      mem_line [DEPTH];
   logic [LA_W-1:0]   mem_addr [DEPTH];
   logic [DEPTH-1:0]  mem_fault;

   logic              in_seq;
   logic              push_try;
   logic              push_ok;
   logic              pop;
   logic              bypass;
   logic              enq;

   assign line_in_rdy = (state != StIdle) && (count < CNT_W'(DEPTH));
   assign fq_count    = count;

   assign in_seq   = (line_in_addr[ADDR_W-1:6] == expected_line);
   assign push_try = line_in_en && line_in_rdy && !flush;
   assign push_ok  = push_try && in_seq;
   assign pop      = follow_req && (count != '0) && (state == StRun) && !flush;

`ifdef FOREIGN_FQ_BYPASS_EN
   // Empty queue with a waiting request: hand the line straight to the decoder.
   assign bypass = push_ok && follow_req && (count == '0) && (state == StRun);
`else
   assign bypass = 1'b0;
`endif

   assign enq = push_ok && !bypass;

   // Storage carries no reset; entries are only read after being written.
   always_ff @(posedge clk) begin
      if (enq) begin
         mem_line[tail]  <= line_in;
         mem_addr[tail]  <= line_in_addr[ADDR_W-1:6];
         mem_fault[tail] <= line_in_fault;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= StIdle;
         head           <= '0;
         tail           <= '0;
         count          <= '0;
         expected_line  <= '0;
         data_out       <= '0;
         data_out_addr  <= '0;
         data_out_en    <= 1'b0;
         data_out_error <= 1'b0;
         seq_err        <= 1'b0;
         ovf_err        <= 1'b0;
      end else begin
         data_out_en <= 1'b0;
         seq_err     <= 1'b0;
         if (line_in_en && !line_in_rdy && (state != StIdle)) begin
            ovf_err <= 1'b1;
         end
         if (flush) begin
            state         <= StRun;
            expected_line <= flush_addr[ADDR_W-1:6];
            count         <= '0;
            head          <= '0;
            tail          <= '0;
         end else begin
            if (push_try && !in_seq) begin
               seq_err <= 1'b1;
            end
            if (push_ok) begin
               expected_line <= expected_line + 1'b1;
            end
            if (enq) begin
               tail <= tail + 1'b1;
            end
            if (pop) begin
               data_out       <= mem_line[head];
               data_out_addr  <= {mem_addr[head], 6'b0};
               data_out_error <= mem_fault[head];
               data_out_en    <= 1'b1;
               head           <= head + 1'b1;
               if (mem_fault[head]) begin
                  state <= StHalt;
               end
            end
            if (bypass) begin
               data_out       <= line_in;
               data_out_addr  <= {line_in_addr[ADDR_W-1:6], 6'b0};
               data_out_error <= line_in_fault;
               data_out_en    <= 1'b1;
               if (line_in_fault) begin
                  state <= StHalt;
               end
            end
            if (enq && !pop) begin
               count <= count + 1'b1;
            end else if (pop && !enq) begin
               count <= count - 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/foreign_fetch_linequeue.md
Name: foreign_fetch_linequeue

Overview:
- Line buffer directly upstream of the x86 bundle length-decode stage.
- Accepts 64-byte instruction-cache lines, checks that their line addresses are sequential, and queues them in a small FIFO.
- Releases one line per request from the decode stage: the stage pulses its data_in_en_to_follow output, which drives this block's follow_req input.
- A fault on a popped line halts the stream until the front end redirects with a flush.

Parameters:
- DEPTH, 4, number of 512-bit entries; power of two, ≥2.
- ADDR_W, 48, virtual address width; line address is bits [ADDR_W-1:6].

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- line_in  in  512  fetched cache line.
- line_in_en  in  1  line_in valid this cycle.
- line_in_addr  in  ADDR_W  byte address of line_in; bits [5:0] are ignored.
- line_in_fault  in  1  fetch fault for this line (page/permission).
- line_in_rdy  out  1  queue can accept a line.
- follow_req  in  1  decode stage requests the next line.
- flush  in  1  redirect; discard contents.
- flush_addr  in  ADDR_W  new fetch address, sampled with flush.
- data_out  out  512  line to decode stage.
- data_out_en  out  1  one-cycle pulse; data_out is new.
- data_out_addr  out  ADDR_W  line address of data_out, low 6 bits zero.
- data_out_error  out  1  data_out line carries a fault.
- seq_err  out  1  one-cycle pulse: non-sequential line dropped.
- ovf_err  out  1  sticky: line_in_en asserted while line_in_rdy low.
- fq_count  out  $clog2(DEPTH+1)  occupancy.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; pointers and count=0.
  - data_out=0, data_out_addr=0, data_out_en=0, data_out_error=0, seq_err=0, ovf_err=0.
  - line_in_rdy=0 (IDLE).
- States:
  - IDLE: no valid expected address; lines ignored, line_in_rdy=0.
  - RUN: normal operation.
  - HALT: a faulted line has been popped; no pops; pushes continue while space is available.
- Transitions:
  - any state + flush → RUN at next edge: expected_line ← flush_addr[ADDR_W-1:6], count ← 0, data_out_en ← 0 next cycle.
  - RUN + pop of an entry with fault=1 → HALT.
  - HALT leaves only via flush or reset.
- line_in_rdy = (state≠IDLE) && (count<DEPTH); combinational from registered state.
- Push at edge when line_in_en && line_in_rdy && !flush:
  - line_in_addr[ADDR_W-1:6]==expected_line: store {line, line address, fault} at tail; tail++ (wraps mod DEPTH); expected_line++ (wraps mod 2^(ADDR_W-6)).
  - Otherwise: drop the line, seq_err=1 for the next cycle; expected_line unchanged.
- Pop at edge when follow_req && count>0 && state==RUN && !flush:
  - data_out, data_out_addr, data_out_error ← head entry; head++; data_out_en=1 in the following cycle only.
  - data_out, data_out_addr and data_out_error hold between pops.
- follow_req with count==0: no pop and no request memory. The decode stage reasserts follow_req.
- Push and pop in the same edge: both happen, count unchanged. When full, a pop does not raise line_in_rdy in that same cycle.
- flush outranks push and pop in the same edge; the line presented that cycle is discarded.
- ovf_err: set when line_in_en && !line_in_rdy && state≠IDLE; cleared only by reset.
- Latency: earliest data_out_en is 2 cycles after the push edge (push at edge N, pop at edge N+1, data_out_en high during cycle after N+1).

Optional Feature:
- Macro: FOREIGN_FQ_BYPASS_EN.
- Defined: when count==0, state==RUN, !flush, follow_req=1, and a sequential line is pushed in the same edge, the line is written straight to data_out/data_out_addr/data_out_error and is not enqueued. data_out_en is then high in the cycle after the push edge (latency 1). A bypassed faulted line moves state to HALT.
- Undefined: no bypass; latency is exactly as in Behaviour.

Test Plan:
- Reset, flush with flush_addr=0x1000, push lines at 0x1000, 0x1040, 0x1080, then follow_req ×3 → three data_out_en pulses with data_out_addr 0x1000, 0x1040, 0x1080 and matching data; fq_count returns to 0.
- Fill DEPTH=4 lines with no follow_req → line_in_rdy=0, fq_count=4. A 5th line_in_en → ovf_err=1 and the line is not stored. One pop → line_in_rdy=1 next cycle.
- After flush to 0x2000, push a line at 0x2080 → seq_err pulses for 1 cycle, fq_count stays 0. A following push at 0x2000 is accepted.
- Push 0x3000 (fault=0) and 0x3040 (fault=1) and 0x3080, request ×3 → second pulse has data_out_error=1, state=HALT, third request gives no pulse, fq_count=1. Flush to 0x4000 → fq_count=0, stream resumes.
- Assert flush, push and follow_req in the same cycle with count=2 → fq_count=0, no data_out_en, line discarded. Assert rst mid-stream → all outputs 0 immediately, line_in_rdy=0.
- With FOREIGN_FQ_BYPASS_EN defined, queue empty: push 0x5000 while follow_req=1 → data_out_en the next cycle with data_out_addr=0x5000, fq_count stays 0. Without the macro, data_out_en comes one cycle later.
